// File: rtl/boot_loader_pkg.sv
// Shared types for the ICCM boot loader: frame-parser states and error codes.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/iccm_boot_loader.sv
// Framed boot-image loader: parses SYNC/LEN/DATA/CSUM bytes, writes LE words to ICCM, releases core reset on a clean image.
// Each word is written the cycle after its 4th byte; byte input has no backpressure, so every strobe is consumed.
module iccm_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int          AW          = 12,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int          TIMEOUT_CYC = 2_000_000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          rx_dv_i,
    input  logic [7:0]    rx_byte_i,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [31:0]   wdata_o,
    output logic          core_rst_no,
    output logic          busy_o,
    output logic          done_o,
    output logic [1:0]    err_o
);

    localparam int LW = AW + 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMAX = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_e        state;
    err_e          err_q;
    logic [7:0]    sum_q;
    logic [7:0]    len_lo_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] widx_q;
    logic [1:0]    bcnt_q;
    logic [23:0]   shreg_q;
    logic [TW-1:0] tcnt_q;

    logic [16:0]   len_field;
    logic          len_bad;
    logic          csum_ok;

    assign len_field = {1'b0, rx_byte_i, len_lo_q};
    assign len_bad   = (len_field == 17'd0) || (len_field > (17'd1 << AW));
    assign csum_ok   = (8'(sum_q + rx_byte_i) == 8'h00);
    assign err_o     = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            err_q       <= ERR_NONE;
            we_o        <= 1'b0;
            addr_o      <= '0;
            wdata_o     <= '0;
            core_rst_no <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            sum_q       <= '0;
            len_lo_q    <= '0;
            len_q       <= '0;
            widx_q      <= '0;
            bcnt_q      <= '0;
            shreg_q     <= '0;
            tcnt_q      <= '0;
        end else begin
            we_o <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (rx_dv_i && rx_byte_i == SYNC_BYTE) begin
                        state       <= LEN_LO;
                        err_q       <= ERR_NONE;
                        done_o      <= 1'b0;
                        core_rst_no <= 1'b0;
                        busy_o      <= 1'b1;
                        sum_q       <= '0;
                        widx_q      <= '0;
                        bcnt_q      <= '0;
                        tcnt_q      <= '0;
                    end
                end
                default: begin
                    if (rx_dv_i) begin
                        tcnt_q <= '0;
                        sum_q  <= sum_q + rx_byte_i;
                        case (state)
                            LEN_LO: begin
                                len_lo_q <= rx_byte_i;
                                state    <= LEN_HI;
                            end
                            LEN_HI: begin
                                if (len_bad) begin
                                    state  <= ERR;
                                    err_q  <= ERR_LEN;
                                    busy_o <= 1'b0;
                                end else begin
                                    len_q <= LW'(len_field);
                                    state <= DATA;
                                end
                            end
                            DATA: begin
                                bcnt_q <= bcnt_q + 2'd1;
                                if (bcnt_q == 2'd3) begin
                                    we_o    <= 1'b1;
                                    addr_o  <= widx_q[AW-1:0];
                                    wdata_o <= {rx_byte_i, shreg_q};
                                    widx_q  <= widx_q + LW'(1);
                                    // Last word: the write pulse lands while the checksum byte may already arrive.
                                    if (widx_q == len_q - LW'(1)) begin
                                        state <= CSUM;
                                    end
                                end else begin
                                    shreg_q <= {rx_byte_i, shreg_q[23:8]};
                                end
                            end
                            CSUM: begin
                                busy_o <= 1'b0;
                                if (csum_ok) begin
                                    state       <= DONE;
                                    done_o      <= 1'b1;
                                    core_rst_no <= 1'b1;
                                end else begin
                                    state <= ERR;
                                    err_q <= ERR_CSUM;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end else if (TIMEOUT_CYC != 0 && tcnt_q == TMAX) begin
                        state  <= ERR;
                        err_q  <= ERR_TIMEOUT;
                        busy_o <= 1'b0;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iccm_boot_loader.sv
// Directed bench for iccm_boot_loader with a frame-level reference model and a per-cycle write scoreboard.
module tb_iccm_boot_loader;

    localparam int AW = 12;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          core_rst_n;
    logic          busy;
    logic          done;
    logic [1:0]    err;

    always #5 clk = ~clk;

    iccm_boot_loader #(.AW(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rx_dv_i    (rx_dv),
        .rx_byte_i  (rx_byte),
        .we_o       (we),
        .addr_o     (addr),
        .wdata_o    (wdata),
        .core_rst_no(core_rst_n),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    frame[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    int            wr_count = 0;
    logic [AW-1:0] last_addr = '0;
    logic [31:0]   last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every write must match the next expected (addr, word) from the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("core_rst_tracks_done", {31'd0, core_rst_n}, {31'd0, done});
            if (we) begin
                if (exp_addr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_we: got addr %h data %h expected no write", addr, wdata);
                end else begin
                    check("wr_addr", {20'd0, addr}, {20'd0, exp_addr.pop_front()});
                    check("wr_data", wdata, exp_data.pop_front());
                end
                wr_count++;
                last_addr = addr;
                last_data = wdata;
            end
        end
    end

    // Reference model: interprets the whole frame, queues expected writes, returns the expected error code.
    task automatic model_frame(output int exp_err);
        int n;
        int s;
        n = {frame[2], frame[1]};
        if (n == 0 || n > (1 << AW)) begin
            exp_err = 1;
        end else begin
            s = frame[1] + frame[2];
            for (int w = 0; w < n; w++) begin
                exp_addr.push_back(AW'(w));
                exp_data.push_back({frame[3+4*w+3], frame[3+4*w+2], frame[3+4*w+1], frame[3+4*w]});
                for (int k = 0; k < 4; k++) s += frame[3+4*w+k];
            end
            s += frame[3+4*n];
            exp_err = ((s % 256) == 0) ? 0 : 2;
        end
    endtask

    task automatic build(input int n, input int seed, input bit good);
        logic [7:0] s;
        logic [7:0] b;
        frame = {};
        frame.push_back(8'hA5);
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        s = n[7:0] + n[15:8];
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'((i * 7 + seed) ^ (i >> 8));
            frame.push_back(b);
            s = s + b;
        end
        frame.push_back(good ? 8'(-s) : 8'(1 - s));
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_dv   = 1'b1;
        @(posedge clk);
        #1;
        rx_dv   = 1'b0;
    endtask

    task automatic send_frame();
        foreach (frame[i]) send_byte(frame[i]);
    endtask

    task automatic run_frame(input string tag);
        int e;
        model_frame(e);
        send_frame();
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_err"},     {30'd0, err},        32'(e));
        check({tag, "_done"},    {31'd0, done},       {31'd0, e == 0});
        check({tag, "_corerst"}, {31'd0, core_rst_n}, {31'd0, e == 0});
        check({tag, "_busy"},    {31'd0, busy},       32'd0);
        check({tag, "_pending"}, 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},      {31'd0, we},         32'd0);
        check({tag, "_addr"},    {20'd0, addr},       32'd0);
        check({tag, "_wdata"},   wdata,               32'd0);
        check({tag, "_corerst"}, {31'd0, core_rst_n}, 32'd0);
        check({tag, "_busy"},    {31'd0, busy},       32'd0);
        check({tag, "_done"},    {31'd0, done},       32'd0);
        check({tag, "_err"},     {30'd0, err},        32'd0);
    endtask

    initial begin
        int wr0;
        int e;
        rst_n   = 1'b0;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-word good frame.
        frame = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEB};
        wr0 = wr_count;
        run_frame("t1");
        check("t1_wrcnt", 32'(wr_count - wr0), 32'd1);
        check("t1_addr",  {20'd0, last_addr}, 32'd0);
        check("t1_data",  last_data, 32'h12345678);
        check("t1_done",  {31'd0, done}, 32'd1);

        // Bad checksum: word still written, then recovery with a good frame.
        frame = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEC};
        wr0 = wr_count;
        run_frame("t2");
        check("t2_err",     {30'd0, err}, 32'd2);
        check("t2_corerst", {31'd0, core_rst_n}, 32'd0);
        check("t2_wrcnt",   32'(wr_count - wr0), 32'd1);
        frame = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEB};
        run_frame("t2r");
        check("t2r_done", {31'd0, done}, 32'd1);

        // Length errors: zero words, and one word beyond the ICCM.
        wr0 = wr_count;
        frame = {8'hA5, 8'h00, 8'h00};
        model_frame(e);
        send_frame();
        check("t3_err_now",  {30'd0, err}, 32'(e));
        check("t3_err_lit",  {30'd0, err}, 32'd1);
        check("t3_busy",     {31'd0, busy}, 32'd0);
        frame = {8'hA5, 8'h01, 8'h10};
        model_frame(e);
        send_byte(8'hA5);
        check("t3_sync_clr", {30'd0, err}, 32'd0);
        check("t3_sync_bsy", {31'd0, busy}, 32'd1);
        send_byte(8'h01);
        send_byte(8'h10);
        check("t3b_err",     {30'd0, err}, 32'(e));
        check("t3b_err_lit", {30'd0, err}, 32'd1);
        check("t3_wrcnt",    32'(wr_count - wr0), 32'd0);

        // Full-size image, back-to-back bytes.
        build(1 << AW, 3, 1'b1);
        wr0 = wr_count;
        run_frame("t4");
        check("t4_wrcnt", 32'(wr_count - wr0), 32'd4096);
        check("t4_last",  {20'd0, last_addr}, 32'd4095);
        check("t4_done",  {31'd0, done}, 32'd1);

        // Timeout after a stall mid-frame.
        frame = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
        send_frame();
        repeat (TO - 1) @(posedge clk);
        #1;
        check("t5_err_before", {30'd0, err}, 32'd0);
        check("t5_busy_before", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check("t5_err_at", {30'd0, err}, 32'd3);
        check("t5_busy_at", {31'd0, busy}, 32'd0);
        send_byte(8'hA5);
        check("t5_clr", {30'd0, err}, 32'd0);
        repeat (TO + 2) @(posedge clk);
        #1;
        check("t5_err_again", {30'd0, err}, 32'd3);

        // Reset mid-DATA after one word, then garbage and a clean reload.
        exp_addr.push_back('0);
        exp_data.push_back(32'h11223344);
        frame = {8'hA5, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h55};
        send_frame();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        check("t6_pending", 32'(exp_addr.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("t6_garbage_busy", {31'd0, busy}, 32'd0);
        build(2, 9, 1'b1);
        run_frame("t6");
        check("t6_last", {20'd0, last_addr}, 32'd1);
        check("t6_done", {31'd0, done}, 32'd1);

        check("final_pending", 32'(exp_addr.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
